// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port (WE3/WA3/WD3) between
// the ALU writeback source (req0) and the load writeback source (req1).
// Round-robin on ties, one registered output stage, read-hazard flags and a
// saturating count of contention cycles.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DISCARD_R0 = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  output logic              a1_pending,
  output logic              a2_pending,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [0:0] {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  prio_e             prio_q, prio_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant0_s;
  logic              grant1_s;
  logic              rf_we_s;

  // An address whose writes are swallowed: the handshake completes, nothing commits.
  function automatic logic addr_dropped(input logic [ADDR_W-1:0] addr);
    return (DISCARD_R0 != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Hazard check for one decode source address against every write in flight.
  function automatic logic addr_pending(
    input logic [ADDR_W-1:0] chk,
    input logic              out_we,
    input logic [ADDR_W-1:0] out_wa,
    input logic              v0,
    input logic [ADDR_W-1:0] a0,
    input logic              v1,
    input logic [ADDR_W-1:0] a1
  );
    logic hit;
    hit = (out_we && (out_wa == chk)) || (v0 && (a0 == chk)) || (v1 && (a1 == chk));
    return hit && !addr_dropped(chk);
  endfunction

  // Grant selection: a lone requester wins, a tie is settled by the priority state.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      case (prio_q)
        PRIO0:   grant0_s = 1'b1;
        PRIO1:   grant1_s = 1'b1;
        default: grant0_s = 1'b1;
      endcase
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state: priority toggle on grant, output stage load, saturating conflict count.
  always_comb begin
    prio_d = prio_q;
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    cnt_d  = cnt_q;
    if (grant0_s) begin
      prio_d = PRIO1;
      we_d   = !addr_dropped(req0_addr);
      wa_d   = req0_addr;
      wd_d   = req0_data;
    end else if (grant1_s) begin
      prio_d = PRIO0;
      we_d   = !addr_dropped(req1_addr);
      wa_d   = req1_addr;
      wd_d   = req1_data;
    end else begin
      prio_d = prio_q;
      we_d   = 1'b0;
    end
    if (req0_valid && req1_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= PRIO0;
      we_q   <= 1'b0;
      wa_q   <= {ADDR_W{1'b0}};
      wd_q   <= {DATA_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      prio_q <= prio_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      cnt_q  <= cnt_d;
    end
  end

  // A write still sitting in the output stage when reset rises must not reach the RF.
  assign rf_we_s = we_q && !reset;

  // Read-hazard flags for the two decode source addresses.
  always_comb begin
    a1_pending = addr_pending(chk_a1, rf_we_s, wa_q, req0_valid, req0_addr,
                              req1_valid, req1_addr);
    a2_pending = addr_pending(chk_a2, rf_we_s, wa_q, req0_valid, req0_addr,
                              req1_valid, req1_addr);
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign rf_we        = rf_we_s;
  assign rf_wa        = wa_q;
  assign rf_wd        = wd_q;
  assign conflict_cnt = cnt_q;

endmodule
